cmd_sched: RTL and testbench

- Shares the single command port of tx_ctrl_top (dev_id/mod_id/cmd_addr/cmd_data/cmd_vld) between NREQ on-chip requesters.
- Sequences one frame at a time:
  - round-robin grant;
  - one-cycle cmd_vld issue;
  - wait for the serial frame to start, then finish;
  - enforce an inter-frame gap.
- Sits in clk_sys domain between command sources (cmd_gen, local config logic) and tx_ctrl_top in top_s.

---
 rtl/cmd_sched_pkg.sv | 24 ++
 rtl/cmd_sched_rr_arb.sv | 35 +++
 rtl/cmd_sched.sv | 134 +++++++++++++
 tb/tb_cmd_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command scheduler: command word layout,
// scheduler state encoding and a small constant helper.
package cmd_sched_pkg;

  localparam int unsigned CMD_W    = 32;
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned DEV_MSB  = 31;
  localparam int unsigned MOD_MSB  = 23;
  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned DATA_MSB = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } sched_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_sched_rr_arb.sv
// Round-robin search: returns the first asserted request at or above
// rr_ptr, wrapping modulo NREQ. Purely combinational; the pointer
// register lives in the parent.
//   req     : per-requester request levels
//   rr_ptr  : index where the search starts
//   grant   : selected requester index (valid when any_req)
//   any_req : at least one request is asserted
module rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   grant,
  output logic            any_req
);

  logic [PW:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // rr_ptr + i < 2*NREQ, so a single conditional subtract wraps it
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!any_req && req[idx[PW-1:0]]) begin
        grant   = idx[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// Shares the tx_ctrl_top command port between NREQ requesters, one frame
// at a time: round-robin grant, one-cycle cmd_vld issue, wait for the
// frame to start (with timeout) and finish, then an inter-frame gap.
//   clk_sys, rst_n       : clock, async active-low reset
//   req / req_cmd        : per-requester request level and 32-bit command
//   ack                  : one-hot accept pulse, coincident with cmd_vld
//   dev_id..cmd_data     : issued command fields, held until next grant
//   cmd_vld              : one-cycle issue strobe
//   tx_busy              : frame in progress from tx_ctrl_top
//   sched_busy           : scheduler not idle
//   err_timeout          : frame failed to start within BUSY_TO cycles
module cmd_sched
  import cmd_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BUSY_TO = 64,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           dev_id,
  output logic [7:0]           mod_id,
  output logic [7:0]           cmd_addr,
  output logic [7:0]           cmd_data,
  output logic                 cmd_vld,
  input  logic                 tx_busy,
  output logic                 sched_busy,
  output logic                 err_timeout
);

  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(max_u(BUSY_TO, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);
  // GAP_CYC of 0 still spends one cycle in GAP
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  sched_state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PW-1:0]    rr_ptr, gnt_q, gnt, ptr_nxt;
  logic             any_req, load;
  logic [CMD_W-1:0] cmds [NREQ];
  logic [CMD_W-1:0] sel_cmd;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign cmds[i] = req_cmd[i*CMD_W +: CMD_W];
  end

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (gnt),
    .any_req (any_req)
  );

  assign sel_cmd = cmds[gnt];
  assign ptr_nxt = (32'(gnt) == NREQ - 1) ? '0 : gnt + PW'(1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      dev_id   <= '0;
      mod_id   <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        gnt_q    <= gnt;
        rr_ptr   <= ptr_nxt;
        dev_id   <= sel_cmd[DEV_MSB  -: FIELD_W];
        mod_id   <= sel_cmd[MOD_MSB  -: FIELD_W];
        cmd_addr <= sel_cmd[ADDR_MSB -: FIELD_W];
        cmd_data <= sel_cmd[DATA_MSB -: FIELD_W];
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    load        = 1'b0;
    cmd_vld     = 1'b0;
    err_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_vld = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt == BUSY_LAST) begin
          err_timeout = 1'b1;
          cnt_d       = '0;
          state_d     = S_GAP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack        = cmd_vld ? (NREQ'(1) << gnt_q) : '0;
    sched_busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_cmd_sched.sv
module tb_cmd_sched;

  logic         clk_sys = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_cmd;
  logic [3:0]   ack;
  logic [7:0]   dev_id, mod_id, cmd_addr, cmd_data;
  logic         cmd_vld, tx_busy, sched_busy, err_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int ack_cnt = 0;
  int bad_cnt = 0;
  int ack_hist [4] = '{0, 0, 0, 0};

  cmd_sched #(.NREQ(4), .BUSY_TO(64), .GAP_CYC(16)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .req         (req),
    .req_cmd     (req_cmd),
    .ack         (ack),
    .dev_id      (dev_id),
    .mod_id      (mod_id),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_vld     (cmd_vld),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (cmd_vld) vld_cnt++;
      ack_cnt += $countones(ack);
      if (!cmd_vld && ack != 4'b0) bad_cnt++;
      for (int i = 0; i < 4; i++) if (ack[i]) ack_hist[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_vld(input int max, output int n);
    n = 0;
    while (!cmd_vld && n < max) begin
      tick();
      n++;
    end
    chk("vld_seen", 32'(cmd_vld), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (sched_busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(sched_busy), 32'd0);
  endtask

  task automatic set_cmd(input int idx, input logic [31:0] c);
    req_cmd[idx*32 +: 32] = c;
  endtask

  initial begin
    int n;
    int ack1_snap;
    int ack_snap;
    rst_n   = 1'b0;
    req     = '0;
    req_cmd = '0;
    tx_busy = 1'b0;
    repeat (3) tick();
    chk("rst_outs", {ack, cmd_vld, sched_busy, err_timeout}, 32'd0);
    chk("rst_fields", {dev_id, mod_id, cmd_addr, cmd_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single request, latency and field decode
    set_cmd(2, 32'h0501_10A5);
    req[2] = 1'b1;
    wait_vld(10, n);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_fields", {dev_id, mod_id, cmd_addr, cmd_data}, 32'h0501_10A5);
    req[2] = 1'b0;
    tick(); tick(); tick();
    tx_busy = 1'b1;
    repeat (200) tick();
    chk("t1_busy_hold", {28'd0, sched_busy, cmd_vld, err_timeout, 1'b0}, 32'h8);
    chk("t1_fields_held", {dev_id, mod_id, cmd_addr, cmd_data}, 32'h0501_10A5);
    tx_busy = 1'b0;
    set_cmd(2, 32'h0602_20B6);
    req[2] = 1'b1;
    wait_vld(60, n);
    chk("t1_gap_to_next", 32'(n), 32'd18);
    chk("t1_ack2", 32'(ack), 32'h4);
    chk("t1_fields2", {dev_id, mod_id, cmd_addr, cmd_data}, 32'h0602_20B6);
    req[2] = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    wait_idle(60);

    // rotation with all requesters active; reset first so pointer is 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_cmd(i, {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)});
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_vld(60, n);
      chk("t2_ack", 32'(ack), 32'(1) << (k % 4));
      chk("t2_dev", 32'(dev_id), 32'h10 + 32'(k % 4));
      chk("t2_data", 32'(cmd_data), 32'h40 + 32'(k % 4));
      if (k == 4) req = '0;
      tick();
      tx_busy = 1'b1;
      tick(); tick();
      tx_busy = 1'b0;
    end
    wait_idle(60);

    // timeout: tx_busy never rises
    set_cmd(0, 32'hDEAD_BEEF);
    req[0] = 1'b1;
    wait_vld(10, n);
    chk("t3_ack", 32'(ack), 32'h1);
    req[0] = 1'b0;
    n = 0;
    while (!err_timeout && n < 200) begin
      tick();
      n++;
    end
    chk("t3_err_seen", 32'(err_timeout), 32'd1);
    chk("t3_err_latency", 32'(n), 32'd64);
    tick();
    chk("t3_err_pulse", {30'd0, err_timeout, sched_busy}, 32'h1);
    n = 1;
    while (sched_busy && n < 100) begin
      tick();
      n++;
    end
    chk("t3_gap_len", 32'(n), 32'd17);
    ack_snap = ack_cnt;
    repeat (5) tick();
    chk("t3_no_reack", 32'(ack_cnt), 32'(ack_snap));

    // withdrawal of req[1] while req[3] stays held
    set_cmd(3, 32'h3333_3333);
    req[0] = 1'b1;
    wait_vld(10, n);
    chk("t4_ack0", 32'(ack), 32'h1);
    req[0] = 1'b0;
    ack1_snap = ack_hist[1];
    tick();
    tx_busy = 1'b1;
    tick();
    req[1] = 1'b1;
    req[3] = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
    repeat (5) tick();
    req[1] = 1'b0;
    wait_vld(40, n);
    chk("t4_ack3", 32'(ack), 32'h8);
    chk("t4_fields", {dev_id, mod_id, cmd_addr, cmd_data}, 32'h3333_3333);
    req[3] = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    wait_idle(60);
    chk("t4_no_ack1", 32'(ack_hist[1]), 32'(ack1_snap));

    // reset mid-frame; pointer must return to 0
    set_cmd(2, 32'hAABB_CCDD);
    req[2] = 1'b1;
    wait_vld(10, n);
    chk("t5_ack2", 32'(ack), 32'h4);
    req[2] = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {ack, cmd_vld, sched_busy, err_timeout}, 32'd0);
    chk("t5_rst_fields", {dev_id, mod_id, cmd_addr, cmd_data}, 32'd0);
    tx_busy = 1'b0;
    set_cmd(0, 32'h0102_0304);
    set_cmd(3, 32'h0908_0706);
    req = 4'b1001;
    tick(); tick();
    rst_n = 1'b1;
    wait_vld(10, n);
    chk("t5_ack_first", 32'(ack), 32'h1);
    chk("t5_fields", {dev_id, mod_id, cmd_addr, cmd_data}, 32'h0102_0304);
    req = '0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    wait_idle(60);

    tick();
    chk("vld_eq_ack", 32'(vld_cnt), 32'(ack_cnt));
    chk("vld_total", 32'(vld_cnt), 32'd12);
    chk("ack_outside_issue", 32'(bad_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
